// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/squash control: load-use, jumps, dmem wait, halt drain.
// Ports: ID/EX/MEM/WB hazard sources in; stall/flush/bubble, halted, mem_err, stall_cycles out.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  p0_addr_ID,
  input  logic [3:0]  p1_addr_ID,
  input  logic        p0_used_ID,
  input  logic        p1_used_ID,
  input  logic        hlt_ID,
  input  logic [3:0]  dst_addr_EX,
  input  logic        we_rf_EX,
  input  logic        re_mem_EX,
  input  logic        j_ctrl_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_rdy,
  input  logic        hlt_WB,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        stall_id_ex,
  output logic        bubble_ex,
  output logic        stall_ex_mem,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q;
  logic        p0_hit, p1_hit;
  logic        load_use, mem_busy;
  logic        timeout;
  logic        cnt_inc;

  assign p0_hit   = p0_used_ID & (p0_addr_ID == dst_addr_EX);
  assign p1_hit   = p1_used_ID & (p1_addr_ID == dst_addr_EX);
  assign load_use = re_mem_EX & we_rf_EX
                  & (dst_addr_EX != 4'd0)
                  & (p0_hit | p1_hit);
  assign mem_busy = mem_req_MEM & ~mem_rdy;
  assign timeout  = (wait_q == WMAX);

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    bubble_ex    = 1'b0;
    stall_ex_mem = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    if (state_q == HALTED) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      halted       = 1'b1;
    end else if (mem_busy) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      if (state_q == RUN) begin
        state_d = MEM_WAIT;
        wait_d  = 8'd1;
      end else if (timeout) begin
        err_d   = 1'b1;
        state_d = HALTED;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end else if (state_q == MEM_WAIT) begin
      wait_d  = 8'd0;
      state_d = RUN;
    end else if (state_q == DRAIN) begin
      wait_d      = 8'd0;
      stall_pc    = 1'b1;
      flush_if_id = 1'b1;
      if (hlt_WB) begin
        state_d = HALTED;
      end
    end else begin
      wait_d = 8'd0;
      // A taken jump squashes ID, so its HLT or load-use is moot.
      if (j_ctrl_EX) begin
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end else if (hlt_ID) begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        state_d     = DRAIN;
      end
    end
  end

  assign cnt_inc = (state_q != HALTED)
                 & (stall_if_id | bubble_ex | stall_ex_mem)
                 & (cnt_q != 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (cnt_inc) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign mem_err      = err_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (WAIT_MAX = 4).
// Drives hazard scenarios and checks controls, state effects and counters.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  p0_addr_ID, p1_addr_ID;
  logic        p0_used_ID, p1_used_ID;
  logic        hlt_ID;
  logic [3:0]  dst_addr_EX;
  logic        we_rf_EX, re_mem_EX, j_ctrl_EX;
  logic        mem_req_MEM, mem_rdy, hlt_WB;
  logic        stall_pc, stall_if_id, flush_if_id;
  logic        stall_id_ex, bubble_ex, stall_ex_mem;
  logic        halted, mem_err;
  logic [15:0] stall_cycles;
  logic [6:0]  outs;

  int errors = 0;
  int checks = 0;

  // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, bubble_ex, stall_ex_mem, halted}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_JMP  = 7'b0010100;
  localparam logic [6:0] O_BUSY = 7'b1101010;
  localparam logic [6:0] O_DRN  = 7'b1010000;
  localparam logic [6:0] O_HLT  = 7'b1101011;

  pipe_hazard_ctrl #(.WAIT_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_addr_ID   (p0_addr_ID),
    .p1_addr_ID   (p1_addr_ID),
    .p0_used_ID   (p0_used_ID),
    .p1_used_ID   (p1_used_ID),
    .hlt_ID       (hlt_ID),
    .dst_addr_EX  (dst_addr_EX),
    .we_rf_EX     (we_rf_EX),
    .re_mem_EX    (re_mem_EX),
    .j_ctrl_EX    (j_ctrl_EX),
    .mem_req_MEM  (mem_req_MEM),
    .mem_rdy      (mem_rdy),
    .hlt_WB       (hlt_WB),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .flush_if_id  (flush_if_id),
    .stall_id_ex  (stall_id_ex),
    .bubble_ex    (bubble_ex),
    .stall_ex_mem (stall_ex_mem),
    .halted       (halted),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  assign outs = {stall_pc, stall_if_id, flush_if_id,
                 stall_id_ex, bubble_ex, stall_ex_mem, halted};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_addr_ID  = 4'd0;
    p1_addr_ID  = 4'd0;
    p0_used_ID  = 1'b0;
    p1_used_ID  = 1'b0;
    hlt_ID      = 1'b0;
    dst_addr_EX = 4'd0;
    we_rf_EX    = 1'b0;
    re_mem_EX   = 1'b0;
    j_ctrl_EX   = 1'b0;
    mem_req_MEM = 1'b0;
    mem_rdy     = 1'b0;
    hlt_WB      = 1'b0;
  endtask

  // LW R3 in EX, consumer reading R3 on port 1
  task automatic lu_r3();
    re_mem_EX   = 1'b1;
    we_rf_EX    = 1'b1;
    dst_addr_EX = 4'd3;
    p1_used_ID  = 1'b1;
    p1_addr_ID  = 4'd3;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outs", 16'(outs), 16'(O_NONE));
    chk("rst_err", 16'(mem_err), 16'd0);
    chk("rst_cnt", stall_cycles, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // load-use: one bubble, then clear
    lu_r3();
    #1 chk("lu_stall", 16'(outs), 16'(O_LU));
    cyc();
    idle();
    #1 chk("lu_after", 16'(outs), 16'(O_NONE));
    chk("lu_cnt", stall_cycles, 16'd1);

    // R0 destination never hazards
    re_mem_EX   = 1'b1;
    we_rf_EX    = 1'b1;
    dst_addr_EX = 4'd0;
    p0_used_ID  = 1'b1;
    p0_addr_ID  = 4'd0;
    #1 chk("lu_r0", 16'(outs), 16'(O_NONE));
    // matching address on an unused source
    dst_addr_EX = 4'd3;
    p0_used_ID  = 1'b0;
    p0_addr_ID  = 4'd3;
    #1 chk("lu_unused", 16'(outs), 16'(O_NONE));
    cyc();
    idle();
    #1 chk("r0_cnt", stall_cycles, 16'd1);

    // taken jump beats HLT and load-use in ID
    lu_r3();
    j_ctrl_EX = 1'b1;
    hlt_ID    = 1'b1;
    #1 chk("jmp_outs", 16'(outs), 16'(O_JMP));
    cyc();
    idle();
    #1 chk("jmp_stay_run", 16'(outs), 16'(O_NONE));
    chk("jmp_cnt", stall_cycles, 16'd2);

    // 3 busy cycles, released on mem_rdy
    mem_req_MEM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw_busy%0d", i), 16'(outs), 16'(O_BUSY));
      cyc();
    end
    mem_rdy = 1'b1;
    #1 chk("mw_release", 16'(outs), 16'(O_NONE));
    chk("mw_cnt", stall_cycles, 16'd5);
    cyc();
    idle();
    lu_r3();
    #1 chk("mw_back_run", 16'(outs), 16'(O_LU));
    cyc();
    idle();

    // halt drain: HLT in ID, HLT in WB three cycles later
    hlt_ID = 1'b1;
    #1 chk("hlt_id", 16'(outs), 16'(O_DRN));
    cyc();
    hlt_ID = 1'b0;
    #1 chk("drain1", 16'(outs), 16'(O_DRN));
    cyc();
    #1 chk("drain2", 16'(outs), 16'(O_DRN));
    cyc();
    hlt_WB = 1'b1;
    #1 chk("drain3", 16'(outs), 16'(O_DRN));
    cyc();
    hlt_WB = 1'b0;
    #1 chk("halted", 16'(outs), 16'(O_HLT));
    chk("hlt_cnt", stall_cycles, 16'd6);
    cyc();
    #1 chk("halted_stays", 16'(outs), 16'(O_HLT));
    chk("hlt_cnt2", stall_cycles, 16'd6);

    // reset out of HALTED
    rst_n = 1'b0;
    #1 chk("rst_hlt_outs", 16'(outs), 16'(O_NONE));
    chk("rst_hlt_cnt", stall_cycles, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // reset mid-DRAIN
    hlt_ID = 1'b1;
    cyc();
    hlt_ID = 1'b0;
    #1 chk("drain_pre", 16'(outs), 16'(O_DRN));
    rst_n = 1'b0;
    #1 chk("rst_drain", 16'(outs), 16'(O_NONE));
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // timeout with WAIT_MAX = 4: halted from the 5th edge
    mem_req_MEM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("to_busy%0d", i), 16'(outs), 16'(O_BUSY));
      chk($sformatf("to_err%0d", i), 16'(mem_err), 16'd0);
      cyc();
    end
    #1 chk("to_halted", 16'(outs), 16'(O_HLT));
    chk("to_err", 16'(mem_err), 16'd1);
    chk("to_cnt", stall_cycles, 16'd5);
    mem_rdy = 1'b1;
    cyc();
    #1 chk("to_halt_keep", 16'(outs), 16'(O_HLT));
    chk("to_err_keep", 16'(mem_err), 16'd1);

    // reset clears sticky error
    rst_n = 1'b0;
    #1 chk("rst_to_err", 16'(mem_err), 16'd0);
    chk("rst_to_hlt", 16'(halted), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cyc();

    // reset mid-MEM_WAIT, memory still busy
    mem_req_MEM = 1'b1;
    cyc();
    cyc();
    chk("mw_pre_cnt", stall_cycles, 16'd2);
    rst_n = 1'b0;
    #1 chk("rst_mw_outs", 16'(outs), 16'(O_BUSY));
    chk("rst_mw_cnt", stall_cycles, 16'd0);
    chk("rst_mw_err", 16'(mem_err), 16'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // saturation via back-to-back load-use bubbles
    lu_r3();
    for (int i = 0; i < 65534; i++) begin
      cyc();
    end
    chk("sat_fffe", stall_cycles, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      cyc();
    end
    chk("sat_ffff", stall_cycles, 16'hFFFF);
    #1 chk("sat_outs", 16'(outs), 16'(O_LU));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
